// File: rtl/map_color_search.sv
`default_nettype none
// ============================================================================
// Module      : map_color_search
// Description : Drives every candidate 4-coloring of the Oz regions onto the
//               validity checker and streams valid colorings over valid/ready.
//               Optional macro MAP_SEARCH_SYMBREAK_EN pins EC to 0 (256 cands).
// Revision    : 1.0 - initial release
// ============================================================================
module map_color_search #(
  parameter int STOP_AFTER = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  GC,
  output logic [1:0]  WC,
  output logic [1:0]  QC,
  output logic [1:0]  MC,
  output logic [1:0]  EC,
  input  logic        chk_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_coloring,
  output logic [10:0] count,
  output logic        busy,
  output logic        done
);

`ifdef MAP_SEARCH_SYMBREAK_EN
  localparam int CAND_W = 8;
`else
  localparam int CAND_W = 10;
`endif

  localparam logic [CAND_W-1:0] LAST_CAND = {CAND_W{1'b1}};
  localparam logic [CAND_W-1:0] CAND_ONE  = {{(CAND_W-1){1'b0}}, 1'b1};
  localparam logic [10:0]       STOP_LIM  = 11'(STOP_AFTER);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic              out_valid_q, out_valid_d;
  logic [9:0]        out_coloring_q, out_coloring_d;
  logic [10:0]       count_q, count_d;

  logic [9:0]        coloring;
  logic [10:0]       count_inc;
  logic              is_last;
  logic              stop_hit;

`ifdef MAP_SEARCH_SYMBREAK_EN
  assign coloring = {cand_q, 2'b00};
`else
  assign coloring = cand_q;
`endif

  assign GC           = coloring[9:8];
  assign WC           = coloring[7:6];
  assign QC           = coloring[5:4];
  assign MC           = coloring[3:2];
  assign EC           = coloring[1:0];
  assign out_valid    = out_valid_q;
  assign out_coloring = out_coloring_q;
  assign count        = count_q;
  assign busy         = (state_q == ST_SCAN) || (state_q == ST_HOLD);
  assign done         = (state_q == ST_DONE);

  assign count_inc = count_q + 11'd1;
  assign is_last   = (cand_q == LAST_CAND);
  assign stop_hit  = (STOP_AFTER != 0) && (count_inc == STOP_LIM);

  always_comb begin
    state_d        = state_q;
    cand_d         = cand_q;
    out_valid_d    = out_valid_q;
    out_coloring_d = out_coloring_q;
    count_d        = count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cand_d  = '0;
          count_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A hit parks on the current candidate until it has been handed off.
        if (chk_valid) begin
          out_coloring_d = coloring;
          out_valid_d    = 1'b1;
          state_d        = ST_HOLD;
        end else if (is_last) begin
          state_d = ST_DONE;
        end else begin
          cand_d = cand_q + CAND_ONE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          count_d     = count_inc;
          if (stop_hit || is_last) begin
            state_d = ST_DONE;
          end else begin
            cand_d  = cand_q + CAND_ONE;
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cand_q         <= '0;
      out_valid_q    <= 1'b0;
      out_coloring_q <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      out_valid_q    <= out_valid_d;
      out_coloring_q <= out_coloring_d;
      count_q        <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_color_search.sv
`default_nettype none
// Testbench for map_color_search: Oz checker model, expected coloring list
// built by direct enumeration, randomized backpressure.
module tb_map_color_search;

`ifdef MAP_SEARCH_SYMBREAK_EN
  localparam int         N_CAND    = 256;
  localparam logic [9:0] EXP_FIRST = 10'h198;
  localparam logic [9:0] EXP_LAST  = 10'h3B8;
  localparam int         EXP_NUM   = 18;
`else
  localparam int         N_CAND    = 1024;
  localparam logic [9:0] EXP_FIRST = 10'h046;
  localparam logic [9:0] EXP_LAST  = 10'h3B9;
  localparam int         EXP_NUM   = 72;
`endif
  localparam int GUARD = 5000;

  logic        clk;
  logic        rst_n;
  logic        start, start5;
  logic        out_ready, out_ready5;
  logic        chk_force_zero;

  logic [1:0]  gc, wc, qc, mc, ec;
  logic        chk_valid, out_valid, busy, done;
  logic [9:0]  out_coloring;
  logic [10:0] count;

  logic [1:0]  gc5, wc5, qc5, mc5, ec5;
  logic        chk_valid5, out_valid5, busy5, done5;
  logic [9:0]  out_coloring5;
  logic [10:0] count5;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Oz map: GC-WC-QC-MC form a ring, Emerald City touches all four.
  function automatic logic coloring_ok(input logic [9:0] c);
    logic [1:0] g, w, q, m, e;
    g = c[9:8]; w = c[7:6]; q = c[5:4]; m = c[3:2]; e = c[1:0];
    return !(g == w || w == q || q == m || m == g ||
             e == g || e == w || e == q || e == m);
  endfunction

  assign chk_valid  = chk_force_zero ? 1'b0 : coloring_ok({gc, wc, qc, mc, ec});
  assign chk_valid5 = coloring_ok({gc5, wc5, qc5, mc5, ec5});

  map_color_search dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .GC(gc), .WC(wc), .QC(qc), .MC(mc), .EC(ec),
    .chk_valid(chk_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_coloring(out_coloring), .count(count), .busy(busy), .done(done)
  );

  map_color_search #(.STOP_AFTER(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5),
    .GC(gc5), .WC(wc5), .QC(qc5), .MC(mc5), .EC(ec5),
    .chk_valid(chk_valid5), .out_valid(out_valid5), .out_ready(out_ready5),
    .out_coloring(out_coloring5), .count(count5), .busy(busy5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic build_expected();
    logic [9:0] c;
    for (int i = 0; i < N_CAND; i++) begin
`ifdef MAP_SEARCH_SYMBREAK_EN
      c = {i[7:0], 2'b00};
`else
      c = i[9:0];
`endif
      if (coloring_ok(c)) exp_q.push_back(c);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || count !== 11'd0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b done=%b count=%0d required 0 0 0 0",
               out_valid, busy, done, count);
    end
    checks++;
    if ({gc, wc, qc, mc, ec} !== 10'd0 || out_coloring !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: got cand=%h out=%h required 000 000",
               {gc, wc, qc, mc, ec}, out_coloring);
    end
    checks++;
    if ({out_valid5, busy5, done5} !== 3'b000 || count5 !== 11'd0) begin
      errors++;
      $display("FAIL reset_stop5: got valid=%b busy=%b done=%b count=%0d required 0 0 0 0",
               out_valid5, busy5, done5, count5);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    int hs = 0;
    int cyc = 0;
    int guard = 0;
    logic [9:0] first_c = '0;
    logic [9:0] last_c = '0;
    out_ready = 1'b1;
    pulse_start();
    while (done !== 1'b1 && guard < GUARD) begin
      guard++;
      if (busy === 1'b1) cyc++;
      checks++;
      if (count !== 11'(hs)) begin
        errors++;
        $display("FAIL full_count_track: got %0d required %0d", count, hs);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (hs >= exp_q.size() || out_coloring !== exp_q[hs]) begin
          errors++;
          $display("FAIL full_coloring[%0d]: got %h required %h", hs, out_coloring,
                   (hs < exp_q.size()) ? exp_q[hs] : 10'h3FF);
        end
        checks++;
        if (out_coloring[1:0] !== 2'b00 && N_CAND == 256) begin
          errors++;
          $display("FAIL full_ec_zero: got EC=%0d required 0", out_coloring[1:0]);
        end
        if (hs == 0) first_c = out_coloring;
        last_c = out_coloring;
        hs++;
      end
      @(negedge clk);
    end
    checks++;
    if (guard >= GUARD) begin
      errors++;
      $display("FAIL full_timeout: got %0d cycles without done required done", guard);
    end
    checks++;
    if (hs != EXP_NUM || count !== 11'(EXP_NUM)) begin
      errors++;
      $display("FAIL full_total: got handshakes=%0d count=%0d required %0d", hs, count, EXP_NUM);
    end
    checks++;
    if (first_c !== EXP_FIRST || last_c !== EXP_LAST) begin
      errors++;
      $display("FAIL full_first_last: got %h/%h required %h/%h", first_c, last_c, EXP_FIRST, EXP_LAST);
    end
    checks++;
    if (cyc != N_CAND + EXP_NUM) begin
      errors++;
      $display("FAIL full_cycles: got %0d required %0d", cyc, N_CAND + EXP_NUM);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_state: got valid=%b busy=%b required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_random_ready();
    int hs = 0;
    int guard = 0;
    logic prev_hold = 1'b0;
    logic [9:0] prev_col = '0;
    pulse_start();
    while (done !== 1'b1 && guard < GUARD) begin
      guard++;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_coloring !== prev_col) begin
          errors++;
          $display("FAIL rand_stable: got valid=%b out=%h required 1 %h", out_valid, out_coloring, prev_col);
        end
      end
      checks++;
      if (count !== 11'(hs)) begin
        errors++;
        $display("FAIL rand_count_track: got %0d required %0d", count, hs);
      end
      out_ready = 1'($urandom_range(0, 1));
      start = (guard == 300);
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (hs >= exp_q.size() || out_coloring !== exp_q[hs]) begin
          errors++;
          $display("FAIL rand_coloring[%0d]: got %h required %h", hs, out_coloring,
                   (hs < exp_q.size()) ? exp_q[hs] : 10'h3FF);
        end
        hs++;
        prev_hold = 1'b0;
      end else begin
        prev_hold = (out_valid === 1'b1);
        prev_col  = out_coloring;
      end
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (guard >= GUARD || hs != EXP_NUM || count !== 11'(EXP_NUM)) begin
      errors++;
      $display("FAIL rand_total: got handshakes=%0d count=%0d guard=%0d required %0d",
               hs, count, guard, EXP_NUM);
    end
  endtask

  task automatic test_stop_after();
    int hs = 0;
    int guard = 0;
    out_ready5 = 1'b1;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    while (done5 !== 1'b1 && guard < GUARD) begin
      guard++;
      if (out_valid5 === 1'b1) begin
        checks++;
        if (hs >= 5 || out_coloring5 !== exp_q[hs]) begin
          errors++;
          $display("FAIL stop5_coloring[%0d]: got %h required %h", hs, out_coloring5,
                   (hs < 5) ? exp_q[hs] : 10'h3FF);
        end
        hs++;
      end
      @(negedge clk);
    end
    checks++;
    if (guard >= GUARD || hs != 5 || count5 !== 11'd5 || out_valid5 !== 1'b0 || done5 !== 1'b1) begin
      errors++;
      $display("FAIL stop5_end: got hs=%0d count=%0d valid=%b done=%b required 5 5 0 1",
               hs, count5, out_valid5, done5);
    end
  endtask

  task automatic test_reset_mid_hold();
    int guard = 0;
    out_ready = 1'b0;
    pulse_start();
    while (out_valid !== 1'b1 && guard < GUARD) begin guard++; @(negedge clk); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && guard < GUARD) begin guard++; @(negedge clk); end
    @(negedge clk);
    checks++;
    if (guard >= GUARD || count !== 11'd1 || out_valid !== 1'b1 || out_coloring !== exp_q[1]) begin
      errors++;
      $display("FAIL hold_setup: got count=%0d valid=%b out=%h required 1 1 %h",
               count, out_valid, out_coloring, exp_q[1]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || count !== 11'd0 || {gc, wc, qc, mc, ec} !== 10'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_reset: got valid=%b count=%0d cand=%h busy=%b done=%b required 0 0 000 0 0",
               out_valid, count, {gc, wc, qc, mc, ec}, busy, done);
    end
    out_ready = 1'b1;
    pulse_start();
    guard = 0;
    while (out_valid !== 1'b1 && guard < GUARD) begin guard++; @(negedge clk); end
    checks++;
    if (out_coloring !== exp_q[0]) begin
      errors++;
      $display("FAIL rescan_first: got %h required %h", out_coloring, exp_q[0]);
    end
    while (done !== 1'b1 && guard < GUARD) begin guard++; @(negedge clk); end
    checks++;
    if (guard >= GUARD || count !== 11'(EXP_NUM)) begin
      errors++;
      $display("FAIL rescan_total: got count=%0d guard=%0d required %0d", count, guard, EXP_NUM);
    end
  endtask

  task automatic test_force_zero();
    int cyc = 0;
    int seen = 0;
    int guard = 0;
    chk_force_zero = 1'b1;
    out_ready = 1'b1;
    pulse_start();
    checks++;
    if (done !== 1'b0 || count !== 11'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_restart: got done=%b count=%0d busy=%b required 0 0 1", done, count, busy);
    end
    while (done !== 1'b1 && guard < GUARD) begin
      guard++;
      if (busy === 1'b1) cyc++;
      if (out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (guard >= GUARD || cyc != N_CAND || seen != 0 || count !== 11'd0) begin
      errors++;
      $display("FAIL zero_scan: got cycles=%0d valid_seen=%0d count=%0d required %0d 0 0",
               cyc, seen, count, N_CAND);
    end
    chk_force_zero = 1'b0;
    pulse_start();
    checks++;
    if (done !== 1'b0 || count !== 11'd0) begin
      errors++;
      $display("FAIL second_start: got done=%b count=%0d required 0 0", done, count);
    end
    guard = 0;
    while (done !== 1'b1 && guard < GUARD) begin guard++; @(negedge clk); end
    checks++;
    if (guard >= GUARD || count !== 11'(EXP_NUM)) begin
      errors++;
      $display("FAIL second_total: got count=%0d required %0d", count, EXP_NUM);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start5 = 1'b0;
    out_ready = 1'b0;
    out_ready5 = 1'b0;
    chk_force_zero = 1'b0;
    build_expected();
    @(negedge clk);
    test_reset();
    test_full_scan();
    test_random_ready();
    test_stop_after();
    test_reset_mid_hold();
    test_force_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/map_color_search.md
Name: map_color_search

Overview:
- Upstream stimulus and collection stage for the combinational Oz map-coloring validity checker.
- Steps through every candidate 4-coloring of the five Oz regions (GC, WC, QC, MC, EC) and drives each candidate onto the checker inputs.
- Samples the checker's validity result for each candidate.
- Streams every valid coloring out over a valid/ready handshake and keeps a running count of valid colorings.

Parameters:
- STOP_AFTER, 0, stop the scan once this many valid colorings have been handed off; 0 means unlimited (full scan).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a scan; ignored unless the block is in IDLE or DONE.
- GC  output  2  candidate color, Gillikin Country (drives the checker).
- WC  output  2  candidate color, Winkie Country.
- QC  output  2  candidate color, Quadling Country.
- MC  output  2  candidate color, Munchkin Country.
- EC  output  2  candidate color, Emerald City.
- chk_valid  input  1  checker result for the candidate currently on GC..EC; combinational, same cycle.
- out_valid  output  1  out_coloring holds a valid coloring.
- out_ready  input  1  downstream accepts out_coloring.
- out_coloring  output  10  {GC,WC,QC,MC,EC} of the captured valid coloring.
- count  output  11  number of valid colorings handed off in this scan.
- busy  output  1  high in SCAN or HOLD.
- done  output  1  high in DONE; held until the next accepted start.

Behaviour:
- Candidate index: 10-bit register cand. GC=cand[9:8], WC=cand[7:6], QC=cand[5:4], MC=cand[3:2], EC=cand[1:0]. GC..EC are driven directly from cand.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - cand=0, out_valid=0, out_coloring=0, count=0, busy=0, done=0.
  - Reset has priority over every other event, including mid-scan, and the scan is abandoned.
- IDLE or DONE, start=1: cand<=0, count<=0, done<=0, next state SCAN. The first candidate is evaluated on the following cycle.
- SCAN (one candidate per cycle):
  - If chk_valid=1: out_coloring<=cand, out_valid<=1, next state HOLD. cand is not advanced.
  - Else, if cand is the last index: next state DONE.
  - Else: cand<=cand+1.
- HOLD:
  - out_valid stays high and out_coloring stays stable until out_ready=1.
  - On the handshake cycle (out_valid & out_ready): out_valid<=0 and count<=count+1.
  - Then, if STOP_AFTER!=0 and count+1==STOP_AFTER, or cand is the last index: next state DONE.
  - Otherwise: cand<=cand+1, next state SCAN.
  - out_ready while out_valid=0 has no effect.
- DONE: done=1, busy=0, and cand and count are held. start restarts the scan.
- start while busy is ignored.
- Throughput: with out_ready tied high, a full scan takes 1024 SCAN cycles plus one HOLD cycle per valid coloring.
- count never wraps: 11 bits covers the maximum of 1024.
- Last index is 1023 with the optional feature off and 255 with it on.

Optional Feature:
- Macro: MAP_SEARCH_SYMBREAK_EN (color-permutation symmetry breaking).
- Defined:
  - EC is forced to 0.
  - cand is 8 bits, mapped as GC=cand[7:6], WC=cand[5:4], QC=cand[3:2], MC=cand[1:0].
  - The scan covers 256 candidates.
  - out_coloring is still {GC,WC,QC,MC,EC} with EC=2'b00.
  - count width and port list are unchanged.
- Undefined: the full 1024-candidate scan described above.

Test Plan:
- Reset, then start with out_ready=1 and a reference checker model → first out_coloring=10'h046, last=10'h3B9; done rises with count=72; scan completes in 1024+72 cycles after the first SCAN cycle.
- Same as above but out_ready toggled pseudo-randomly → out_coloring stable while out_valid=1 and out_ready=0; same 72 colorings in ascending order; count=72.
- STOP_AFTER=5 → exactly 5 handshakes, then done=1 with count=5 and out_valid=0.
- start pulsed mid-scan → ignored, sequence unchanged. rst_n=0 mid-scan in HOLD → next cycle out_valid=0, count=0, cand=0, state IDLE; a subsequent start rescans from candidate 0.
- chk_valid forced 0 → no out_valid; done after 1024 SCAN cycles with count=0. Second start from DONE clears done and count and rescans.
- MAP_SEARCH_SYMBREAK_EN defined → first out_coloring=10'h198; count=18 at done; all outputs have EC=0; 256+18 cycles with out_ready=1.
